bank_row_encoder: RTL
=====================

# bank_row_encoder

Sequential row-index encoder for the memory bank; it performs the inverse of the word-line decode. It captures a 1024-bit row flag vector (sense/match results, one bit per word line) and serially emits the 10-bit index of every set bit, lowest index first, over a valid/ready stream. Its output stream can drive the bank word-line decoder's select input directly, with the handshake gating the word-line enable.

## Interface
Parameters:
- ROWS, 1024, number of row flags; fixed at 1024 in this revision.
- IDX_W, 10, index width, log2(ROWS).
- GRP, 32, bits per search group; ROWS/GRP groups are used for the two-level search.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  capture `row_flags` and begin a scan; honoured only in IDLE.
- abort  in  1  synchronous abort of the current scan.
- row_flags  in  1024  flag vector; bit i corresponds to row i.
- idx_ready  in  1  downstream accepts `idx` this cycle.
- idx  out  10  index of the current flagged row.
- idx_valid  out  1  `idx` is valid.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when a scan completes (not asserted on abort).
- hit_count  out  11  indices accepted in the current or last scan (0..1024).

## Operation
- State machine: IDLE, SCAN, DONE.
- Registers:
  - `pending` [1023:0]: flags still to emit.
  - `idx` and `idx_valid`: output holding register.
  - `hit_count`.
- Next-index search (combinational, on `pending`):
  - Compute a 32-bit group-nonzero vector and select the lowest nonzero group g.
  - Select the lowest set bit b within group g.
  - Next index = g*32 + b.
- IDLE:
  - `start`=1: `pending` <= `row_flags`, `hit_count` <= 0, `idx_valid` <= 0, go to SCAN.
- SCAN, load condition = (!`idx_valid`) or (`idx_valid` and `idx_ready`):
  - Load condition true and `pending`≠0: `idx` <= next index, `idx_valid` <= 1, clear that bit in `pending`.
  - Load condition true and `pending`=0: `idx_valid` <= 0, go to DONE.
  - Load condition false: hold `idx`, `idx_valid`, `pending`.
  - `hit_count` increments on every cycle with `idx_valid` and `idx_ready`.
- DONE: `done`=1 for this cycle only; return to IDLE.
- `abort` (any state, overrides `start`): `idx_valid` <= 0, `pending` <= 0, go to IDLE, no `done` pulse; `hit_count` keeps the value reached.
- `start` while in SCAN or DONE: ignored.
- `row_flags` is sampled only at the start edge; later changes have no effect on the current scan.
- Handshake rules:
  - `idx` must be stable while `idx_valid`=1 and `idx_ready`=0.
  - `idx_valid` never drops without a completed handshake, except on abort or reset.
- Width rules:
  - `hit_count` is 11 bits, so 1024 hits do not wrap.
  - Index arithmetic is unsigned; there is no overflow path.

## Timing
- Reset (async assert): state=IDLE, `pending`=0, `idx`=0, `idx_valid`=0, `busy`=0, `done`=0, `hit_count`=0.
- Release: synchronous to `clk`.
- Start accepted at edge N: `busy`=1 after N.
- First index: loaded at edge N+1, so `idx_valid`=1 from N+1.
- Latency from start to first index: 2 edges.
- Throughput: 1 index/cycle while `idx_ready`=1. With k set bits and `idx_ready` held high:
  - last index is valid after edge N+k;
  - DONE is entered at edge N+k+1, `done` is high for one cycle;
  - IDLE is reached at edge N+k+2.
- Empty vector: DONE at edge N+1, `done` high one cycle, IDLE at N+2, `idx_valid` never asserted.
- `start` in the cycle `done` is high: ignored. A new start is accepted no earlier than the following edge.
- Reset asserted mid-scan: outputs take their reset values immediately, independent of `clk`.

## Test plan
- Reset mid-scan with `idx_valid`=1 -> all outputs 0 immediately; the next scan from IDLE behaves normally.
- `row_flags` bits {3, 31, 32, 1023}, `idx_ready`=1 -> `idx` 3, 31, 32, 1023 on consecutive cycles starting 2 edges after start; one `done` pulse; `hit_count`=4.
- `row_flags`=0 -> `done` 2 edges after start, `idx_valid` never high, `hit_count`=0.
- `row_flags` all ones, `idx_ready` toggling 1/0 -> 0..1023 in order, `idx` stable during stalls, `hit_count`=1024, `done` once.
- Bits {5, 700}, `idx_ready`=0 for 10 cycles after the first valid -> `idx`=5 held for 10 cycles, then 700; `start` pulses during SCAN ignored.
- Bits {1, 2, 3}, abort after the first handshake -> `idx_valid` 0 next cycle, no `done`, `hit_count`=1, IDLE; a new start re-captures `row_flags`.

Source files
------------

// File: rtl/bank_row_encoder.sv
// Sequential row-index encoder: captures a row flag vector and streams out
// the index of every set flag, lowest first, over a valid/ready handshake.
// A two-level search (group-nonzero, then bit-within-group) finds the next
// pending index each cycle, so one index can be emitted per clock.
module bank_row_encoder #(
  parameter int ROWS  = 1024,
  parameter int IDX_W = 10,
  parameter int GRP   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROWS-1:0]  row_flags,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   hit_count
);

  localparam int NGRP = ROWS / GRP;
  localparam int GB_W = $clog2(GRP);
  localparam int NG_W = $clog2(NGRP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ROWS-1:0]  pending;
  logic [NGRP-1:0]  grp_nz;
  logic [NG_W-1:0]  grp_sel;
  logic [GRP-1:0]   grp_bits;
  logic [GB_W-1:0]  bit_sel;
  logic [IDX_W-1:0] next_idx;
  logic             pending_nz;
  logic             load_cond;
  logic             handshake;

  // Level one: flag every group that still holds a pending row.
  always_comb begin
    grp_nz = '0;
    for (int g = 0; g < NGRP; g++) begin
      grp_nz[g] = |pending[g*GRP +: GRP];
    end
  end

  // Pick the lowest nonzero group; scanning downwards lets the lowest win.
  always_comb begin
    grp_sel = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (grp_nz[g]) grp_sel = NG_W'(g);
    end
  end

  // Level two: lowest set bit inside the selected group.
  always_comb begin
    grp_bits = pending[{grp_sel, {GB_W{1'b0}}} +: GRP];
    bit_sel  = '0;
    for (int b = GRP - 1; b >= 0; b--) begin
      if (grp_bits[b]) bit_sel = GB_W'(b);
    end
  end

  assign next_idx   = {grp_sel, bit_sel};
  assign pending_nz = |grp_nz;
  assign handshake  = idx_valid & idx_ready;
  // The holding register may take a new index when empty or being drained.
  assign load_cond  = ~idx_valid | idx_ready;

  assign busy = (state == S_SCAN);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including start.
  always_comb begin
    // NOTE: assign a default first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_SCAN;
      S_SCAN: if (load_cond && !pending_nz) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Pending flags and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the pending vector is plain flops, not a memory array, so it is
    // reset like any other control register.
    if (!rst_n) begin
      pending   <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
    end else if (abort) begin
      pending   <= '0;
      idx_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pending   <= row_flags;
            idx_valid <= 1'b0;
          end
        end
        S_SCAN: begin
          if (load_cond) begin
            if (pending_nz) begin
              idx               <= next_idx;
              idx_valid         <= 1'b1;
              pending[next_idx] <= 1'b0;
            end else begin
              idx_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Accepted-index counter: cleared by a new scan, kept across abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      hit_count <= '0;
    end else if (handshake) begin
      hit_count <= hit_count + {{IDX_W{1'b0}}, 1'b1};
    end
  end

endmodule
